result_forward_pipe: RTL and testbench
======================================

Name: result_forward_pipe

Overview:
- Producer side of the EX-stage operand-forwarding interface: holds the EX/MEM and MEM/WB pipeline registers that feed the ALU's forwarding inputs.
- Drives the register-file write port from the MEM/WB stage.
- Detects load-use hazards that forwarding cannot cover and raises a one-cycle stall toward fetch/decode.
- Sits between the ALU/EX stage and the data memory and register file.

Parameters:
- N, 16, datapath width of results and memory data.
- R, 3, register-index width.
- CW, 16, width of the saturating stall-event counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash the instruction entering EX/MEM (branch/interrupt redirect).
- ex_valid  in  1  EX stage holds a real instruction (0 = bubble).
- ex_result  in  N  ALU output of the EX instruction.
- ex_dst  in  R  destination register index of the EX instruction.
- ex_wb  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_mem_write  in  1  EX instruction is a store.
- mem_data_in  in  N  data-memory read data for the instruction in EX/MEM.
- id_src  in  R  decode-stage source register index.
- id_dst  in  R  decode-stage second operand register index.
- id_src_used, id_dst_used  in  1 each  decode instruction actually reads that operand.
- result_prev1  out  N  EX/MEM result (newer forward source).
- reg2_buf2  out  R  EX/MEM destination index.
- wb1, mem_write1  out  1 each  EX/MEM write-back and store flags.
- mem_read1  out  1  EX/MEM load flag.
- result_prev2  out  N  MEM/WB result (older forward source).
- reg2_buf3  out  R  MEM/WB destination index.
- wb2, mem_write2  out  1 each  MEM/WB write-back and store flags.
- mem_read_load_case  out  1  MEM/WB instruction was a load.
- memory_data_output_load_case  out  N  load data captured into MEM/WB.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  R  register-file write index.
- rf_wdata  out  N  register-file write data.
- stall  out  1  load-use stall request (combinational).
- stall_count  out  CW  saturating count of stall cycles.

Behaviour:
- Reset (rst=1 at edge): every registered output is 0, covering all result, index, flag, load-data fields and stall_count. rf_we is therefore 0. Reset has highest priority and overrides flush and normal advance in the same cycle.
- EX/MEM update each edge, priority rst > flush > advance:
  - If flush=1 or ex_valid=0, load a bubble: wb1=0, mem_read1=0, mem_write1=0, result_prev1=0, reg2_buf2=0.
  - Otherwise result_prev1<=ex_result, reg2_buf2<=ex_dst, wb1<=ex_wb, mem_read1<=ex_mem_read, mem_write1<=ex_mem_write.
- MEM/WB update each edge (not affected by flush):
  - result_prev2<=result_prev1, reg2_buf3<=reg2_buf2, wb2<=wb1, mem_write2<=mem_write1.
  - mem_read_load_case<=mem_read1.
  - memory_data_output_load_case<=mem_data_in when mem_read1=1, else holds its previous value.
- Latency: an EX value is visible on result_prev1 one cycle later and on result_prev2 two cycles later.
- Write-back (combinational from MEM/WB):
  - rf_we=wb2, rf_waddr=reg2_buf3.
  - rf_wdata=memory_data_output_load_case if mem_read_load_case, else result_prev2.
- Stall: stall=ex_valid & ex_wb & ex_mem_read & ((id_src_used & id_src==ex_dst) | (id_dst_used & id_dst==ex_dst)).
  - Stall does not freeze this block. The load advances normally, and upstream supplies ex_valid=0 on the following cycle.
  - Because the bubble clears the match, stall is high for exactly one cycle per hazard.
- stall_count increments by 1 on each edge where stall=1 and rst=0. It saturates at all-ones and never wraps.
- A flush and a stall in the same cycle: flush still squashes EX/MEM, and the stall cycle is still counted.
- Register index 0 has no special meaning; matches on 0 stall like any other index.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, ex_valid=0 -> all outputs 0; rf_we=0, stall=0, stall_count=0.
- ALU chain: ex_result=0x1234, ex_dst=3, ex_wb=1 -> next cycle result_prev1=0x1234, reg2_buf2=3, wb1=1 -> following cycle result_prev2=0x1234, rf_we=1, rf_waddr=3, rf_wdata=0x1234.
- Load write-back: load to r5 with mem_data_in=0xBEEF during EX/MEM, ex_result=0x0010 -> mem_read_load_case=1 and rf_wdata=0xBEEF (not 0x0010), rf_waddr=5.
- Load-use hazard: EX load to r2, id_src=2, id_src_used=1 -> stall=1 for that cycle only; after an upstream bubble stall=0 and stall_count=1. Same case with id_src_used=0 -> stall=0.
- Flush: valid ALU op to r4 with flush=1 -> wb1=0, mem_write1=0 next cycle. MEM/WB still receives the prior EX/MEM contents.
- Saturation and reset mid-run: force 2^CW+3 stall cycles -> stall_count=0xFFFF. Assert rst while EX/MEM holds a valid op -> all state 0 next cycle, rf_we=0.

Source files
------------

// File: rtl/result_forward_pipe.sv
// EX/MEM and MEM/WB pipeline registers feeding the ALU forwarding inputs,
// register-file write-back, and load-use stall detection with a saturating event counter.
module result_forward_pipe #(
    parameter int N  = 16,
    parameter int R  = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [N-1:0]  ex_result,
    input  logic [R-1:0]  ex_dst,
    input  logic          ex_wb,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic [N-1:0]  mem_data_in,
    input  logic [R-1:0]  id_src,
    input  logic [R-1:0]  id_dst,
    input  logic          id_src_used,
    input  logic          id_dst_used,
    output logic [N-1:0]  result_prev1,
    output logic [R-1:0]  reg2_buf2,
    output logic          wb1,
    output logic          mem_write1,
    output logic          mem_read1,
    output logic [N-1:0]  result_prev2,
    output logic [R-1:0]  reg2_buf3,
    output logic          wb2,
    output logic          mem_write2,
    output logic          mem_read_load_case,
    output logic [N-1:0]  memory_data_output_load_case,
    output logic          rf_we,
    output logic [R-1:0]  rf_waddr,
    output logic [N-1:0]  rf_wdata,
    output logic          stall,
    output logic [CW-1:0] stall_count
);

    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    logic src_hit;
    logic dst_hit;
    logic ex_bubble;

    assign ex_bubble = flush || !ex_valid;

    // A load in EX cannot forward to decode in time; either used operand matching stalls.
    always_comb begin
        src_hit = id_src_used && (id_src == ex_dst);
        dst_hit = id_dst_used && (id_dst == ex_dst);
        stall   = ex_valid && ex_wb && ex_mem_read && (src_hit || dst_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_prev1 <= '0;
            reg2_buf2    <= '0;
            wb1          <= 1'b0;
            mem_write1   <= 1'b0;
            mem_read1    <= 1'b0;
        end else if (ex_bubble) begin
            result_prev1 <= '0;
            reg2_buf2    <= '0;
            wb1          <= 1'b0;
            mem_write1   <= 1'b0;
            mem_read1    <= 1'b0;
        end else begin
            result_prev1 <= ex_result;
            reg2_buf2    <= ex_dst;
            wb1          <= ex_wb;
            mem_write1   <= ex_mem_write;
            mem_read1    <= ex_mem_read;
        end
    end

    // MEM/WB ignores flush: an instruction already in EX/MEM has committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_prev2                 <= '0;
            reg2_buf3                    <= '0;
            wb2                          <= 1'b0;
            mem_write2                   <= 1'b0;
            mem_read_load_case           <= 1'b0;
            memory_data_output_load_case <= '0;
        end else begin
            result_prev2       <= result_prev1;
            reg2_buf3          <= reg2_buf2;
            wb2                <= wb1;
            mem_write2         <= mem_write1;
            mem_read_load_case <= mem_read1;
            if (mem_read1) begin
                memory_data_output_load_case <= mem_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != COUNT_MAX)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    always_comb begin
        rf_we    = wb2;
        rf_waddr = reg2_buf3;
        rf_wdata = mem_read_load_case ? memory_data_output_load_case : result_prev2;
    end

endmodule

// File: tb/tb_result_forward_pipe.sv
// Self-checking bench for result_forward_pipe: directed scenarios plus randomized
// traffic compared against a two-slot pipeline model kept in the bench.
module tb_result_forward_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush, ex_valid, ex_wb, ex_mem_read, ex_mem_write;
    logic [15:0] ex_result, mem_data_in;
    logic [2:0]  ex_dst, id_src, id_dst;
    logic        id_src_used, id_dst_used;
    logic [15:0] result_prev1, result_prev2, memory_data_output_load_case, rf_wdata;
    logic [2:0]  reg2_buf2, reg2_buf3, rf_waddr;
    logic        wb1, mem_write1, mem_read1, wb2, mem_write2, mem_read_load_case;
    logic        rf_we, stall;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    result_forward_pipe #(.N(16), .R(3), .CW(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
        .ex_result(ex_result), .ex_dst(ex_dst), .ex_wb(ex_wb),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_data_in(mem_data_in), .id_src(id_src), .id_dst(id_dst),
        .id_src_used(id_src_used), .id_dst_used(id_dst_used),
        .result_prev1(result_prev1), .reg2_buf2(reg2_buf2), .wb1(wb1),
        .mem_write1(mem_write1), .mem_read1(mem_read1),
        .result_prev2(result_prev2), .reg2_buf3(reg2_buf3), .wb2(wb2),
        .mem_write2(mem_write2), .mem_read_load_case(mem_read_load_case),
        .memory_data_output_load_case(memory_data_output_load_case),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  dst;
        logic        wb;
        logic        rd;
        logic        wr;
    } stage_t;

    // Reference model: the instruction one and two slots behind EX, the last load data, stall tally.
    stage_t      m_exm, m_mwb;
    logic [15:0] m_ld;
    int          m_cnt;

    function automatic logic exp_stall();
        logic hit;
        hit = (id_src_used && id_src == ex_dst) || (id_dst_used && id_dst == ex_dst);
        return ex_valid && ex_wb && ex_mem_read && hit;
    endfunction

    function automatic logic [15:0] exp_wdata();
        return m_mwb.rd ? m_ld : m_mwb.res;
    endfunction

    task automatic step();
        stage_t nx;
        logic   s;
        s = exp_stall();
        if (rst) begin
            m_exm = '0; m_mwb = '0; m_ld = '0; m_cnt = 0;
        end else begin
            nx = (flush || !ex_valid) ? stage_t'('0)
                 : stage_t'{ex_result, ex_dst, ex_wb, ex_mem_read, ex_mem_write};
            if (m_exm.rd) m_ld = mem_data_in;
            m_mwb = m_exm;
            m_exm = nx;
            if (s && m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; ex_valid = 0; ex_result = '0; ex_dst = '0; ex_wb = 0;
        ex_mem_read = 0; ex_mem_write = 0; mem_data_in = '0;
        id_src = '0; id_dst = '0; id_src_used = 0; id_dst_used = 0;
    endtask

    task automatic ex_op(input logic [15:0] res, input logic [2:0] dst,
                         input logic wb, input logic rd, input logic wr);
        ex_valid = 1; ex_result = res; ex_dst = dst; ex_wb = wb;
        ex_mem_read = rd; ex_mem_write = wr;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
        n_checks++;
        if ({result_prev1, reg2_buf2, wb1, mem_write1, mem_read1} !== '0) begin
            n_fail++;
            $display("FAIL reset_exmem: got %h/%h/%b%b%b want all 0", result_prev1, reg2_buf2, wb1, mem_write1, mem_read1);
        end
        n_checks++;
        if ({result_prev2, reg2_buf3, wb2, mem_write2, mem_read_load_case, memory_data_output_load_case} !== '0) begin
            n_fail++;
            $display("FAIL reset_memwb: got %h/%h/%b%b%b/%h want all 0", result_prev2, reg2_buf3, wb2, mem_write2, mem_read_load_case, memory_data_output_load_case);
        end
        n_checks++;
        if (rf_we !== 1'b0 || stall !== 1'b0 || stall_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_misc: rf_we=%b stall=%b stall_count=%h want 0 0 0", rf_we, stall, stall_count);
        end
    endtask

    task automatic test_alu_chain();
        idle();
        ex_op(16'h1234, 3'd3, 1, 0, 0);
        step();
        idle();
        n_checks++;
        if (result_prev1 !== 16'h1234 || reg2_buf2 !== 3'd3 || wb1 !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_exmem: got %h r%0d wb=%b want 1234 r3 wb=1", result_prev1, reg2_buf2, wb1);
        end
        step();
        n_checks++;
        if (result_prev2 !== 16'h1234 || rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL alu_wb: got %h we=%b r%0d data=%h want 1234 1 r3 1234", result_prev2, rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_load_writeback();
        idle();
        ex_op(16'h0010, 3'd5, 1, 1, 0);
        step();
        idle();
        mem_data_in = 16'hBEEF;
        step();
        mem_data_in = 16'h5555;
        n_checks++;
        if (mem_read_load_case !== 1'b1 || rf_wdata !== 16'hBEEF || rf_waddr !== 3'd5) begin
            n_fail++;
            $display("FAIL load_wb: got ld=%b data=%h r%0d want 1 beef r5", mem_read_load_case, rf_wdata, rf_waddr);
        end
        step();
        n_checks++;
        if (memory_data_output_load_case !== 16'hBEEF || rf_wdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL load_hold: got held=%h wdata=%h want beef 0000", memory_data_output_load_case, rf_wdata);
        end
    endtask

    task automatic test_load_use_hazard();
        logic [15:0] c0;
        idle();
        c0 = stall_count;
        ex_op(16'h0000, 3'd2, 1, 1, 0);
        id_src = 3'd2; id_src_used = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_src: stall=%b want 1", stall);
        end
        step();
        ex_valid = 0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_bubble: stall=%b want 0", stall);
        end
        n_checks++;
        if (stall_count !== c0 + 16'd1) begin
            n_fail++;
            $display("FAIL hazard_count: got %0d want %0d", stall_count, c0 + 16'd1);
        end
        step();
        ex_op(16'h0000, 3'd2, 1, 1, 0);
        id_src = 3'd2; id_src_used = 0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_unused: stall=%b want 0", stall);
        end
        ex_dst = 3'd0; id_dst = 3'd0; id_dst_used = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_r0: stall=%b want 1", stall);
        end
        step();
        idle();
    endtask

    task automatic test_flush();
        logic [15:0] c0;
        idle();
        ex_op(16'h7777, 3'd7, 1, 0, 0);
        step();
        c0 = stall_count;
        ex_op(16'h4444, 3'd4, 1, 1, 1);
        id_src = 3'd4; id_src_used = 1;
        flush = 1;
        step();
        idle();
        n_checks++;
        if (wb1 !== 1'b0 || mem_write1 !== 1'b0 || mem_read1 !== 1'b0 || reg2_buf2 !== 3'd0 || result_prev1 !== 16'h0) begin
            n_fail++;
            $display("FAIL flush_exmem: got wb=%b wr=%b rd=%b r%0d %h want bubble", wb1, mem_write1, mem_read1, reg2_buf2, result_prev1);
        end
        n_checks++;
        if (reg2_buf3 !== 3'd7 || wb2 !== 1'b1 || result_prev2 !== 16'h7777) begin
            n_fail++;
            $display("FAIL flush_memwb: got r%0d wb=%b %h want r7 1 7777", reg2_buf3, wb2, result_prev2);
        end
        n_checks++;
        if (stall_count !== c0 + 16'd1) begin
            n_fail++;
            $display("FAIL flush_stall_count: got %0d want %0d", stall_count, c0 + 16'd1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flush       = ($urandom_range(0, 7) == 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_result   = 16'($urandom());
            ex_dst      = 3'($urandom());
            ex_wb       = 1'($urandom());
            ex_mem_read = 1'($urandom());
            ex_mem_write = 1'($urandom());
            mem_data_in = 16'($urandom());
            id_src      = 3'($urandom());
            id_dst      = 3'($urandom());
            id_src_used = 1'($urandom());
            id_dst_used = 1'($urandom());
            #1;
            n_checks++;
            if (stall !== exp_stall()) begin
                n_fail++;
                $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, exp_stall());
            end
            step();
            n_checks++;
            if ({result_prev1, reg2_buf2, wb1, mem_read1, mem_write1} !== m_exm) begin
                n_fail++;
                $display("FAIL rnd_exmem[%0d]: got %h want %h", i, {result_prev1, reg2_buf2, wb1, mem_read1, mem_write1}, m_exm);
            end
            n_checks++;
            if ({result_prev2, reg2_buf3, wb2, mem_read_load_case, mem_write2} !== m_mwb
                || memory_data_output_load_case !== m_ld) begin
                n_fail++;
                $display("FAIL rnd_memwb[%0d]: got %h/%h want %h/%h", i,
                         {result_prev2, reg2_buf3, wb2, mem_read_load_case, mem_write2},
                         memory_data_output_load_case, m_mwb, m_ld);
            end
            n_checks++;
            if (rf_we !== m_mwb.wb || rf_waddr !== m_mwb.dst || rf_wdata !== exp_wdata()
                || stall_count !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL rnd_wb[%0d]: got we=%b r%0d %h cnt=%0d want we=%b r%0d %h cnt=%0d", i,
                         rf_we, rf_waddr, rf_wdata, stall_count, m_mwb.wb, m_mwb.dst, exp_wdata(), m_cnt);
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        idle();
        rst = 1;
        step();
        rst = 0;
        ex_op(16'h0000, 3'd6, 1, 1, 0);
        id_dst = 3'd6; id_dst_used = 1;
        for (int i = 0; i < 65536 + 3; i++) begin
            step();
            if (i == 65533) begin
                n_checks++;
                if (stall_count !== 16'hFFFE) begin
                    n_fail++;
                    $display("FAIL sat_before: got %h want fffe", stall_count);
                end
            end
        end
        n_checks++;
        if (stall_count !== 16'hFFFF || m_cnt != 65535) begin
            n_fail++;
            $display("FAIL sat_final: got %h want ffff", stall_count);
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        idle();
        ex_op(16'hA5A5, 3'd1, 1, 1, 1);
        mem_data_in = 16'h1111;
        step();
        step();
        rst = 1;
        flush = 1;
        step();
        rst = 0;
        idle();
        n_checks++;
        if ({result_prev1, reg2_buf2, wb1, mem_write1, mem_read1, result_prev2, reg2_buf3, wb2,
             mem_write2, mem_read_load_case, memory_data_output_load_case} !== '0
            || rf_we !== 1'b0 || stall_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_midrun: got p1=%h p2=%h ld=%h we=%b cnt=%h want all 0",
                     result_prev1, result_prev2, memory_data_output_load_case, rf_we, stall_count);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_chain();
        test_load_writeback();
        test_load_use_hazard();
        test_flush();
        test_random();
        test_saturation();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
